control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Parametrised, multi-cycle successor to the combinational accumulator-ISA decoder.
- Sequences fetch, decode/execute and memory phases with valid/ack handshakes.
- Holds the Z/C/N/V flag register internally and resolves branches against it.
- Adds HALT, memory timeout and error reporting; sits between instruction fetch, register file, ALU and data memory.

Parameters:
INST_W, 9, instruction width; must equal 5+REG_IDX_W
REG_IDX_W, 4, register index width (register 0 = accumulator)
KEY_W, INST_W-4, branch/accumulator-lookup key width (derived localparam)
MEM_TIMEOUT, 15, max cycles waiting for mem_ack; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE/HALT and begin fetching
inst_req  out  1  request next instruction
inst_vld  in  1  inst valid; accepted when inst_req&inst_vld
inst  in  INST_W  instruction word
alu_z, alu_c, alu_n, alu_v  in  1 each  ALU result flags
mem_req  out  1  memory access request, held until ack
mem_we  out  1  1=store, 0=load; valid while mem_req
mem_ack  in  1  memory completion
reg_write_en  out  1  one-cycle register-file write strobe
reg_write_number  out  REG_IDX_W  destination register
reg_from_number  out  REG_IDX_W  source register / address register
reg_to_reg  out  1  write destination from source register
alu_en  out  1  ALU op strobe; result goes to accumulator
branch_en  out  1  one-cycle taken-branch strobe
fetch_acc_en  out  1  accumulator-lookup strobe
key  out  KEY_W  branch/lookup key
flags  out  4  {z,c,n,v} register
halted  out  1  FSM in HALT
err  out  1  sticky memory-timeout error

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0; flags=0; err=0; inst latch=0; timeout counter=0.
- Outputs are registered; strobes are high for exactly one cycle unless stated.
- IDLE: on start -> FETCH.
- FETCH: inst_req=1. On inst_vld, latch inst -> EXEC. inst_req drops the cycle after acceptance.
- EXEC, inst[INST_W-1]=1, op=inst[INST_W-2 -: 3], key=inst[KEY_W-1:0]:
  - 000 BLT: branch_en=n&~z.
  - 001 BGT: branch_en=~n&~z.
  - 010 BEQ: branch_en=z.
  - 011 BR: branch_en=1.
  - 100 ACC: fetch_acc_en=1, reg_write_en=1, reg_write_number=0.
  - 111 HALT: -> HALT.
  - Other ops: no strobes.
  - key is driven for every branch-class op. Every non-HALT op -> FETCH.
- EXEC, inst[INST_W-1]=0, op4=inst[INST_W-2 -: 4], r=inst[REG_IDX_W-1:0]:
  - 0000 LOAD: mem_req=1, mem_we=0, reg_from_number=r -> MEM.
  - 0001 STORE: mem_req=1, mem_we=1, reg_from_number=r -> MEM.
  - 1100 ACC->reg: reg_write_en, reg_to_reg, write=r, from=0.
  - 1101 reg->acc: reg_write_en, reg_to_reg, write=0, from=r.
  - Other op4: ALU op; alu_en, reg_write_en, write=0, from=r; flags captured from alu_* at end of this cycle.
  - Non-memory ops -> FETCH.
- Flag timing: branches use the flags register, i.e. the flags from the most recent ALU op. A branch immediately after an ALU op sees the updated flags.
- MEM:
  - mem_req and mem_we held stable until mem_ack.
  - On ack: mem_req drops next cycle. LOAD pulses reg_write_en with write=0 in the cycle after ack. Then -> FETCH.
  - An ack arriving in the same cycle mem_req first rises is valid.
  - Counter increments each wait cycle. When it reaches MEM_TIMEOUT with no ack: err=1 (sticky), mem_req=0 -> HALT.
- HALT: halted=1, no requests. start -> FETCH; err is retained until reset.
- start is ignored outside IDLE/HALT.
- Reset mid-operation: immediate return to IDLE values; any outstanding mem_req is abandoned.
- Latency: non-memory instruction = 2 cycles minimum (FETCH+EXEC); memory instruction = 3 + ack wait.

Optional Feature:
- Macro CTRL_EXT_BRANCH_EN.
- Defined: branch ops 101 BLE (n|z) and 110 BGE (~n|z) are decoded; op 110 with v=1 uses (n^v)=0 for signed compare.
- Undefined: 101/110 produce no strobes and go to FETCH.

Decomposition:
- Package control_pkg:
  - state enum (IDLE, FETCH, EXEC, MEM, HALT)
  - branch-op and op4 localparam constants
  - flag bit-index constants
- Sub-module branch_resolve: combinational op+flags -> taken, instantiated once.

Test Plan:
- ALU op 0_0011_0101 with alu_n=1,z=0, then BLT 1_000_00111 -> alu_en+reg_write_en from=5; flags=0010; branch_en=1, key=7.
- BEQ with flags z=0 -> branch_en=0, key driven, FSM back to FETCH after 1 EXEC cycle.
- LOAD 0_0000_0011, ack after 3 cycles -> mem_req held 4 cycles, mem_we=0, reg_write_en pulse write=0 the cycle after ack.
- STORE with no ack, MEM_TIMEOUT=15 -> err=1 and halted=1 after 15 wait cycles, mem_req=0.
- HALT 1_111_xxxxx then start -> halted=1, inst_req=0; start resumes FETCH; err unchanged.
- rst_n low during MEM -> all outputs 0 asynchronously, state IDLE, flags=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and encodings for the accumulator-ISA control sequencer.
package control_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StHalt
  } state_e;

  // Branch-class opcodes: inst[INST_W-1] = 1, op = inst[INST_W-2 -: 3]
  localparam logic [2:0] OpBlt  = 3'b000;
  localparam logic [2:0] OpBgt  = 3'b001;
  localparam logic [2:0] OpBeq  = 3'b010;
  localparam logic [2:0] OpBr   = 3'b011;
  localparam logic [2:0] OpAcc  = 3'b100;
  localparam logic [2:0] OpBle  = 3'b101;
  localparam logic [2:0] OpBge  = 3'b110;
  localparam logic [2:0] OpHalt = 3'b111;

  // Register-class opcodes: inst[INST_W-1] = 0, op4 = inst[INST_W-2 -: 4]
  localparam logic [3:0] Op4Load     = 4'b0000;
  localparam logic [3:0] Op4Store    = 4'b0001;
  localparam logic [3:0] Op4AccToReg = 4'b1100;
  localparam logic [3:0] Op4RegToAcc = 4'b1101;

  // Bit positions inside the {z,c,n,v} flag register
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch condition evaluation against the {z,c,n,v} flag register.
// CTRL_EXT_BRANCH_EN adds BLE/BGE decoding; otherwise those opcodes are never taken.
module branch_resolve
  import control_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z, n, v;
  logic unused_flags;

  assign z = flags[FlagZ];
  assign n = flags[FlagN];
  assign v = flags[FlagV];
  assign unused_flags = flags[FlagC] ^ v;

  always_comb begin
    taken = 1'b0;
    case (op)
      OpBlt: taken = n & ~z;
      OpBgt: taken = ~n & ~z;
      OpBeq: taken = z;
      OpBr:  taken = 1'b1;
`ifdef CTRL_EXT_BRANCH_EN
      OpBle: taken = n | z;
      // With overflow set the sign bit is inverted, so compare on n^v instead
      OpBge: taken = v ? ~(n ^ v) : (~n | z);
`endif
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle fetch/execute/memory sequencer for the accumulator ISA with flags and timeout.
// Optional BLE/BGE branches are enabled by defining CTRL_EXT_BRANCH_EN.
module control_fsm
  import control_pkg::*;
#(
  parameter int unsigned INST_W      = 9,
  parameter int unsigned REG_IDX_W   = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 inst_req,
  input  logic                 inst_vld,
  input  logic [INST_W-1:0]    inst,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic                 alu_n,
  input  logic                 alu_v,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic                 mem_ack,
  output logic                 reg_write_en,
  output logic [REG_IDX_W-1:0] reg_write_number,
  output logic [REG_IDX_W-1:0] reg_from_number,
  output logic                 reg_to_reg,
  output logic                 alu_en,
  output logic                 branch_en,
  output logic                 fetch_acc_en,
  output logic [INST_W-5:0]    key,
  output logic [3:0]           flags,
  output logic                 halted,
  output logic                 err
);

  localparam int unsigned KEY_W = INST_W - 4;
  localparam int unsigned CntW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] TimeoutLast =
      CntW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e                 state_q;
  logic [INST_W-1:0]      inst_q;
  logic [CntW-1:0]        cnt_q;
  logic                   inst_req_q, mem_req_q, mem_we_q;
  logic                   reg_write_en_q, reg_to_reg_q;
  logic [REG_IDX_W-1:0]   reg_write_number_q, reg_from_number_q;
  logic                   alu_en_q, branch_en_q, fetch_acc_en_q;
  logic [KEY_W-1:0]       key_q;
  logic [3:0]             flags_q;
  logic                   halted_q, err_q;

  // Decode straight from the incoming word so EXEC-cycle outputs are already registered
  logic                   in_branch_cls;
  logic [2:0]             in_op3;
  logic [3:0]             in_op4;
  logic [REG_IDX_W-1:0]   in_reg;
  logic [KEY_W-1:0]       in_key;
  logic                   in_taken;
  logic                   exec_halt;
  logic                   unused_inst;

  assign in_branch_cls = inst[INST_W-1];
  assign in_op3        = inst[INST_W-2 -: 3];
  assign in_op4        = inst[INST_W-2 -: 4];
  assign in_reg        = inst[REG_IDX_W-1:0];
  assign in_key        = inst[KEY_W-1:0];
  assign exec_halt     = inst_q[INST_W-1] && (inst_q[INST_W-2 -: 3] == OpHalt);
  assign unused_inst   = ^inst_q[KEY_W-1:0];

  branch_resolve u_branch_resolve (
    .op    (in_op3),
    .flags (flags_q),
    .taken (in_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      inst_q             <= '0;
      cnt_q              <= '0;
      inst_req_q         <= 1'b0;
      mem_req_q          <= 1'b0;
      mem_we_q           <= 1'b0;
      reg_write_en_q     <= 1'b0;
      reg_to_reg_q       <= 1'b0;
      reg_write_number_q <= '0;
      reg_from_number_q  <= '0;
      alu_en_q           <= 1'b0;
      branch_en_q        <= 1'b0;
      fetch_acc_en_q     <= 1'b0;
      key_q              <= '0;
      flags_q            <= '0;
      halted_q           <= 1'b0;
      err_q              <= 1'b0;
    end else begin
      reg_write_en_q <= 1'b0;
      alu_en_q       <= 1'b0;
      branch_en_q    <= 1'b0;
      fetch_acc_en_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StFetch;
            inst_req_q <= 1'b1;
          end
        end

        StFetch: begin
          if (inst_vld) begin
            state_q            <= StExec;
            inst_q             <= inst;
            inst_req_q         <= 1'b0;
            cnt_q              <= '0;
            reg_to_reg_q       <= 1'b0;
            reg_write_number_q <= '0;
            reg_from_number_q  <= '0;
            key_q              <= '0;
            if (in_branch_cls) begin
              key_q       <= in_key;
              branch_en_q <= in_taken;
              if (in_op3 == OpAcc) begin
                fetch_acc_en_q <= 1'b1;
                reg_write_en_q <= 1'b1;
              end
            end else if (in_op4 == Op4Load || in_op4 == Op4Store) begin
              mem_req_q         <= 1'b1;
              mem_we_q          <= (in_op4 == Op4Store);
              reg_from_number_q <= in_reg;
            end else if (in_op4 == Op4AccToReg) begin
              reg_write_en_q     <= 1'b1;
              reg_to_reg_q       <= 1'b1;
              reg_write_number_q <= in_reg;
            end else if (in_op4 == Op4RegToAcc) begin
              reg_write_en_q    <= 1'b1;
              reg_to_reg_q      <= 1'b1;
              reg_from_number_q <= in_reg;
            end else begin
              alu_en_q          <= 1'b1;
              reg_write_en_q    <= 1'b1;
              reg_from_number_q <= in_reg;
            end
          end
        end

        StExec: begin
          if (alu_en_q) begin
            flags_q <= {alu_z, alu_c, alu_n, alu_v};
          end
          if (exec_halt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            key_q    <= '0;
          end else if (mem_req_q) begin
            state_q <= StMem;
          end else begin
            state_q            <= StFetch;
            inst_req_q         <= 1'b1;
            reg_to_reg_q       <= 1'b0;
            reg_write_number_q <= '0;
            reg_from_number_q  <= '0;
            key_q              <= '0;
          end
        end

        StMem: begin
          // mem_req already dropped means this is the post-ack write-back cycle
          if (!mem_req_q) begin
            state_q            <= StFetch;
            inst_req_q         <= 1'b1;
            reg_write_number_q <= '0;
            reg_from_number_q  <= '0;
          end
        end

        StHalt: begin
          if (start) begin
            state_q    <= StFetch;
            halted_q   <= 1'b0;
            inst_req_q <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase

      // Handshake is live from the EXEC cycle onward, so a same-cycle ack is honoured
      if (mem_req_q) begin
        if (mem_ack) begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          cnt_q     <= '0;
          if (!mem_we_q) begin
            reg_write_en_q     <= 1'b1;
            reg_write_number_q <= '0;
          end
        end else if (MEM_TIMEOUT != 0) begin
          if (cnt_q == TimeoutLast) begin
            err_q             <= 1'b1;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            cnt_q             <= '0;
            reg_from_number_q <= '0;
            state_q           <= StHalt;
            halted_q          <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      end
    end
  end

  assign inst_req         = inst_req_q;
  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign reg_write_en     = reg_write_en_q;
  assign reg_write_number = reg_write_number_q;
  assign reg_from_number  = reg_from_number_q;
  assign reg_to_reg       = reg_to_reg_q;
  assign alu_en           = alu_en_q;
  assign branch_en        = branch_en_q;
  assign fetch_acc_en     = fetch_acc_en_q;
  assign key              = key_q;
  assign flags            = flags_q;
  assign halted           = halted_q;
  assign err              = err_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed-vector bench for control_fsm: ALU/branch, memory handshake, timeout, halt, reset.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, inst_vld, mem_ack;
  logic [8:0] inst;
  logic       alu_z, alu_c, alu_n, alu_v;
  logic       inst_req, mem_req, mem_we, reg_write_en, reg_to_reg;
  logic       alu_en, branch_en, fetch_acc_en, halted, err;
  logic [3:0] reg_write_number, reg_from_number, flags;
  logic [4:0] key;
  logic [26:0] all_outs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_fsm #(
    .INST_W      (9),
    .REG_IDX_W   (4),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .inst_req         (inst_req),
    .inst_vld         (inst_vld),
    .inst             (inst),
    .alu_z            (alu_z),
    .alu_c            (alu_c),
    .alu_n            (alu_n),
    .alu_v            (alu_v),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_ack          (mem_ack),
    .reg_write_en     (reg_write_en),
    .reg_write_number (reg_write_number),
    .reg_from_number  (reg_from_number),
    .reg_to_reg       (reg_to_reg),
    .alu_en           (alu_en),
    .branch_en        (branch_en),
    .fetch_acc_en     (fetch_acc_en),
    .key              (key),
    .flags            (flags),
    .halted           (halted),
    .err              (err)
  );

  assign all_outs = {inst_req, mem_req, mem_we, reg_write_en, reg_write_number, reg_from_number,
                     reg_to_reg, alu_en, branch_en, fetch_acc_en, key, flags, halted, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [8:0] word);
    inst     = word;
    inst_vld = 1'b1;
    step();
    inst_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; inst_vld = 1'b0; mem_ack = 1'b0; inst = '0;
    alu_z = 1'b0; alu_c = 1'b0; alu_n = 1'b0; alu_v = 1'b0;
    #3;
    check("reset_outs", 32'(all_outs), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_no_req", 32'(inst_req), 32'd0);

    // ALU op r5 with n=1 then BLT key 7
    start = 1'b1;
    step();
    start = 1'b0;
    check("fetch_req", 32'(inst_req), 32'd1);
    issue(9'b0_0011_0101);
    alu_n = 1'b1;
    check("alu_strobes", 32'({alu_en, reg_write_en, reg_to_reg}), 32'b110);
    check("alu_regs", 32'({reg_write_number, reg_from_number}), 32'h05);
    check("alu_req_drop", 32'(inst_req), 32'd0);
    step();
    alu_n = 1'b0;
    check("flags_after_alu", 32'(flags), 32'b0010);
    check("alu_one_cycle", 32'({alu_en, reg_write_en}), 32'd0);
    check("back_to_fetch", 32'(inst_req), 32'd1);
    issue(9'b1_000_00111);
    check("blt_taken", 32'(branch_en), 32'd1);
    check("blt_key", 32'(key), 32'd7);
    step();
    check("blt_one_cycle", 32'({branch_en, inst_req}), 32'b01);

    // BEQ with z=0: not taken, key still driven
    issue(9'b1_010_01010);
    check("beq_not_taken", 32'(branch_en), 32'd0);
    check("beq_key", 32'(key), 32'd10);
    step();
    check("beq_refetch", 32'(inst_req), 32'd1);

    // Accumulator lookup
    issue(9'b1_100_00011);
    check("acc_strobes", 32'({fetch_acc_en, reg_write_en, reg_write_number, key}),
          32'({1'b1, 1'b1, 4'd0, 5'd3}));
    step();

    // ACC->reg r6
    issue(9'b0_1100_0110);
    check("acc_to_reg", 32'({reg_write_en, reg_to_reg, reg_write_number, reg_from_number, alu_en}),
          32'({1'b1, 1'b1, 4'd6, 4'd0, 1'b0}));
    step();

    // LOAD r3, ack on the fourth mem_req cycle
    issue(9'b0_0000_0011);
    for (int i = 0; i < 4; i++) begin
      check("load_req_held", 32'({mem_req, mem_we, reg_from_number}), 32'({1'b1, 1'b0, 4'd3}));
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check("load_req_drop", 32'(mem_req), 32'd0);
    check("load_wb", 32'({reg_write_en, reg_write_number}), 32'({1'b1, 4'd0}));
    step();
    check("load_done", 32'({reg_write_en, inst_req}), 32'b01);

    // STORE r2 acked in the same cycle mem_req rises
    issue(9'b0_0001_0010);
    check("store_req", 32'({mem_req, mem_we, reg_from_number}), 32'({1'b1, 1'b1, 4'd2}));
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("store_fast_ack", 32'({mem_req, reg_write_en}), 32'd0);
    step();
    check("store_refetch", 32'(inst_req), 32'd1);

    // STORE never acked: 15 wait cycles then error + halt
    issue(9'b0_0001_0001);
    for (int i = 0; i < 15; i++) begin
      check("timeout_wait", 32'({mem_req, err, halted}), 32'b100);
      step();
    end
    check("timeout_err", 32'({mem_req, err, halted, inst_req}), 32'b0110);

    // Resume from HALT, then HALT instruction
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume_fetch", 32'({inst_req, halted, err}), 32'b101);
    issue(9'b1_111_00000);
    step();
    check("halt_op", 32'({halted, inst_req, mem_req, err}), 32'b1001);
    step();
    step();
    check("halt_hold", 32'({halted, inst_req}), 32'b10);
    start = 1'b1;
    step();
    start = 1'b0;
    check("halt_restart", 32'({halted, inst_req, err}), 32'b011);

    // Asynchronous reset while waiting on memory
    issue(9'b0_0000_0100);
    step();
    check("pre_reset_mem", 32'({mem_req, flags}), 32'({1'b1, 4'b0010}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'(all_outs), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("reset_to_idle", 32'({inst_req, mem_req, halted}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
